vector_issue_ctrl: RTL and testbench

Registered, multi-cycle successor to the vector ASIP's combinational decode stage. Accepts one 32-bit instruction per valid/ready handshake, decodes the 4-bit opcode, and issues datapath control strobes. Vector ops (SUMFV, MULFV, LDV) are expanded into ceil(N/LANES) beats, each with a per-lane enable mask. N is set by SETN. Sits between the instruction fetch FIFO and the lane datapath.

---
 rtl/vasip_ctrl_pkg.sv | 30 +++
 rtl/lane_mask_gen.sv | 26 ++
 rtl/vector_issue_ctrl.sv | 167 ++++++++++++++++
 tb/tb_vector_issue_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/vasip_ctrl_pkg.sv
// Shared definitions for the vector ASIP control path: opcode encoding,
// the registered strobe bundle and the opcode field position.
package vasip_ctrl_pkg;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;

    typedef enum logic [3:0] {
        OP_INCRI = 4'd0,
        OP_INCRJ = 4'd1,
        OP_SETN  = 4'd2,
        OP_SUMFV = 4'd3,
        OP_MULFV = 4'd4,
        OP_NOP   = 4'd5,
        OP_LDV   = 4'd6
    } opcode_e;

    // Selects first (held across idle/NOP cycles), then the pulsed strobes.
    typedef struct packed {
        logic alu_func;
        logic rd_pos_cte;
        logic rd_pos_pxl;
        logic wr_pxl;
        logic wr_mul_reg;
        logic wr_wom;
        logic incr_i;
        logic incr_j;
    } ctrl_t;

endpackage

// File: rtl/lane_mask_gen.sv
// Per-lane enable for one beat: lane i is active when its element index
// (beat_idx*LANES + i) lies below the vector length.
module lane_mask_gen #(
    parameter int LANES  = 4,
    parameter int N_W    = 7,
    parameter int BEAT_W = 4
) (
    input  logic [N_W-1:0]    vlen,
    input  logic [BEAT_W-1:0] beat_idx,
    output logic [LANES-1:0]  lane_en
);

    // Wide enough that base + lane index never wraps.
    localparam int E_W = BEAT_W + $clog2(LANES) + N_W + 1;

    logic [E_W-1:0] base;
    assign base = E_W'(beat_idx) * E_W'(LANES);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_en[gi] = (base + E_W'(gi)) < E_W'(vlen);
        end
    endgenerate

endmodule

// File: rtl/vector_issue_ctrl.sv
// Registered issue stage: decodes one instruction per handshake and expands
// vector ops into ceil(vlen/LANES) beats with per-lane enables.
module vector_issue_ctrl
    import vasip_ctrl_pkg::*;
#(
    parameter int  LANES  = 4,
    parameter int  MAX_N  = 64,
    localparam int N_W    = $clog2(MAX_N + 1),
    localparam int BEATS_MAX = (MAX_N + LANES - 1) / LANES,
    localparam int BEAT_W = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              alu_func,
    output logic              rd_pos_cte,
    output logic              rd_pos_pxl,
    output logic              wr_pxl,
    output logic              wr_mul_reg,
    output logic              wr_wom,
    output logic              incr_i,
    output logic              incr_j,
    output logic [LANES-1:0]  lane_en,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              busy,
    output logic              illegal
);

    localparam int LOG_L = $clog2(LANES);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e             state_reg, state_next;
    ctrl_t              ctrl_reg, ctrl_next;
    logic [N_W-1:0]     vlen_reg, vlen_next;
    logic [BEAT_W-1:0]  beat_idx_reg, beat_next;
    logic [BEAT_W-1:0]  last_reg, last_next;
    logic [LANES-1:0]   lane_en_reg, lane_en_next;
    logic               busy_reg, busy_next;
    logic               illegal_reg, illegal_next;

    logic               accept;
    logic               lane_gate;
    logic [3:0]         opc;
    logic [N_W-1:0]     setn_val;
    logic [N_W:0]       beats_total;
    logic [BEAT_W-1:0]  beats_m1;
    logic [BEAT_W-1:0]  beat_inc;
    logic [LANES-1:0]   mask;
    logic               unused_instr_bits;

    assign opc               = instr[OPC_MSB:OPC_LSB];
    assign setn_val          = instr[N_W-1:0];
    assign unused_instr_bits = ^instr[25:N_W];
    assign beats_total       = ({1'b0, vlen_reg} + (N_W+1)'(LANES - 1)) >> LOG_L;
    assign beats_m1          = BEAT_W'(beats_total - (N_W+1)'(1));
    assign beat_inc          = beat_idx_reg + BEAT_W'(1);

    // Ready when nothing is expanding, or on the final beat so the next op follows without a bubble.
    assign instr_ready = !rst && (state_reg == IDLE || beat_idx_reg == last_reg);
    assign accept      = instr_valid && instr_ready;

    lane_mask_gen #(
        .LANES  (LANES),
        .N_W    (N_W),
        .BEAT_W (BEAT_W)
    ) u_mask (
        .vlen     (vlen_reg),
        .beat_idx (beat_next),
        .lane_en  (mask)
    );

    assign lane_en_next = lane_gate ? mask : '0;

    // Next-state and next-output decode; selects hold unless an op drives them.
    always_comb begin
        state_next          = IDLE;
        ctrl_next           = '0;
        ctrl_next.alu_func  = ctrl_reg.alu_func;
        ctrl_next.rd_pos_cte = ctrl_reg.rd_pos_cte;
        ctrl_next.rd_pos_pxl = ctrl_reg.rd_pos_pxl;
        beat_next           = '0;
        last_next           = last_reg;
        busy_next           = 1'b0;
        illegal_next        = 1'b0;
        vlen_next           = vlen_reg;
        lane_gate           = 1'b0;
        if (state_reg == ISSUE && beat_idx_reg != last_reg) begin
            state_next = ISSUE;
            ctrl_next  = ctrl_reg;
            beat_next  = beat_inc;
            lane_gate  = 1'b1;
            busy_next  = (beat_inc != last_reg);
        end else if (accept) begin
            case (opc)
                OP_INCRI: ctrl_next.incr_i = 1'b1;
                OP_INCRJ: ctrl_next.incr_j = 1'b1;
                OP_SETN:  vlen_next = (setn_val > N_W'(MAX_N)) ? N_W'(MAX_N) : setn_val;
                OP_SUMFV, OP_MULFV, OP_LDV: begin
                    // A zero-length vector degenerates into a single empty cycle.
                    if (vlen_reg != '0) begin
                        if (opc == OP_SUMFV) begin
                            ctrl_next.alu_func = 1'b0;
                            ctrl_next.wr_wom   = 1'b1;
                        end else if (opc == OP_MULFV) begin
                            ctrl_next.alu_func   = 1'b1;
                            ctrl_next.wr_mul_reg = 1'b1;
                            ctrl_next.rd_pos_cte = instr[27];
                            ctrl_next.rd_pos_pxl = instr[26];
                        end else begin
                            ctrl_next.wr_pxl     = 1'b1;
                            ctrl_next.rd_pos_pxl = instr[27];
                            ctrl_next.rd_pos_cte = 1'b0;
                        end
                        last_next = beats_m1;
                        lane_gate = 1'b1;
                        if (beats_m1 != '0) begin
                            state_next = ISSUE;
                            busy_next  = 1'b1;
                        end
                    end
                end
                OP_NOP:  ;
                default: illegal_next = 1'b1;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            ctrl_reg     <= '0;
            vlen_reg     <= N_W'(LANES);
            beat_idx_reg <= '0;
            last_reg     <= '0;
            lane_en_reg  <= '0;
            busy_reg     <= 1'b0;
            illegal_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ctrl_reg     <= ctrl_next;
            vlen_reg     <= vlen_next;
            beat_idx_reg <= beat_next;
            last_reg     <= last_next;
            lane_en_reg  <= lane_en_next;
            busy_reg     <= busy_next;
            illegal_reg  <= illegal_next;
        end
    end

    assign alu_func   = ctrl_reg.alu_func;
    assign rd_pos_cte = ctrl_reg.rd_pos_cte;
    assign rd_pos_pxl = ctrl_reg.rd_pos_pxl;
    assign wr_pxl     = ctrl_reg.wr_pxl;
    assign wr_mul_reg = ctrl_reg.wr_mul_reg;
    assign wr_wom     = ctrl_reg.wr_wom;
    assign incr_i     = ctrl_reg.incr_i;
    assign incr_j     = ctrl_reg.incr_j;
    assign lane_en    = lane_en_reg;
    assign beat_idx   = beat_idx_reg;
    assign busy       = busy_reg;
    assign illegal    = illegal_reg;

endmodule

// File: tb/tb_vector_issue_ctrl.sv
// Directed bench for vector_issue_ctrl with LANES=4, MAX_N=64.
module tb_vector_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        alu_func, rd_pos_cte, rd_pos_pxl;
    logic        wr_pxl, wr_mul_reg, wr_wom, incr_i, incr_j;
    logic [3:0]  lane_en;
    logic [3:0]  beat_idx;
    logic        busy, illegal;
    logic [7:0]  strb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vector_issue_ctrl #(.LANES(4), .MAX_N(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_func    (alu_func),
        .rd_pos_cte  (rd_pos_cte),
        .rd_pos_pxl  (rd_pos_pxl),
        .wr_pxl      (wr_pxl),
        .wr_mul_reg  (wr_mul_reg),
        .wr_wom      (wr_wom),
        .incr_i      (incr_i),
        .incr_j      (incr_j),
        .lane_en     (lane_en),
        .beat_idx    (beat_idx),
        .busy        (busy),
        .illegal     (illegal)
    );

    // {alu_func, rd_pos_cte, rd_pos_pxl, wr_pxl, wr_mul_reg, wr_wom, incr_i, incr_j}
    assign strb = {alu_func, rd_pos_cte, rd_pos_pxl, wr_pxl, wr_mul_reg, wr_wom, incr_i, incr_j};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string name, input logic [3:0] opc, input logic [27:0] body);
        instr       = {opc, body};
        instr_valid = 1'b1;
        $display("[%0t] issue %s instr=%08h", $time, name, {opc, body});
    endtask

    task automatic beat_check(input string tag, input logic [7:0] s, input logic [3:0] le,
                              input logic [3:0] bi, input logic bz, input logic rdy);
        check({tag, ".strb"},  32'(strb), 32'(s));
        check({tag, ".lane"},  32'(lane_en), 32'(le));
        check({tag, ".beat"},  32'(beat_idx), 32'(bi));
        check({tag, ".busy"},  32'(busy), 32'(bz));
        check({tag, ".ready"}, 32'(instr_ready), 32'(rdy));
    endtask

    initial begin
        rst = 1'b1; instr = '0; instr_valid = 1'b0;
        tick(); tick();
        beat_check("reset", 8'h00, 4'h0, 4'd0, 1'b0, 1'b0);
        check("reset.illegal", 32'(illegal), 32'd0);

        rst = 1'b0; #1;
        check("post_reset.ready", 32'(instr_ready), 32'd1);

        // SETN 10 then SUMFV: 3 beats 1111,1111,0011
        send("SETN 10", 4'h2, 28'd10);   tick();
        check("setn10.strb", 32'(strb), 32'h00);
        send("SUMFV", 4'h3, 28'd0);      tick();
        instr_valid = 1'b0;
        beat_check("sum.b0", 8'b0000_0100, 4'b1111, 4'd0, 1'b1, 1'b0); tick();
        beat_check("sum.b1", 8'b0000_0100, 4'b1111, 4'd1, 1'b1, 1'b0); tick();
        beat_check("sum.b2", 8'b0000_0100, 4'b0011, 4'd2, 1'b0, 1'b1); tick();
        beat_check("sum.idle", 8'b0000_0000, 4'b0000, 4'd0, 1'b0, 1'b1);

        // SETN 200 clamps to 64; MULFV cte=1 pxl=0 -> 16 beats
        send("SETN 200", 4'h2, 28'd200); tick();
        send("MULFV 10", 4'h4, {2'b10, 26'd0}); tick();
        instr_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            beat_check($sformatf("mul.b%0d", k), 8'b1100_1000, 4'b1111, 4'(k), (k < 15), (k == 15));
            tick();
        end
        beat_check("mul.idle", 8'b1100_0000, 4'b0000, 4'd0, 1'b0, 1'b1);

        // SETN 4; MULFV cte=0 pxl=1 single beat, then NOP holds selects
        send("SETN 4", 4'h2, 28'd4);     tick();
        send("MULFV 01", 4'h4, {2'b01, 26'd0}); tick();
        beat_check("mul1.b0", 8'b1010_1000, 4'b1111, 4'd0, 1'b0, 1'b1);
        send("NOP", 4'h5, 28'd0);        tick();
        beat_check("nop", 8'b1010_0000, 4'b0000, 4'd0, 1'b0, 1'b1);
        check("nop.illegal", 32'(illegal), 32'd0);

        // Undefined opcode pulses illegal for exactly one cycle
        send("OPC F", 4'hF, 28'd0);      tick();
        check("illegal.pulse", 32'(illegal), 32'd1);
        check("illegal.strb", 32'(strb), 32'h0000_00A0);
        check("illegal.lane", 32'(lane_en), 32'd0);
        instr_valid = 1'b0;              tick();
        check("illegal.clear", 32'(illegal), 32'd0);

        // SETN 0 then LDV: one empty cycle
        send("SETN 0", 4'h2, 28'd0);     tick();
        send("LDV vlen0", 4'h6, {1'b1, 27'd0}); tick();
        beat_check("ldv0", 8'b1010_0000, 4'b0000, 4'd0, 1'b0, 1'b1);

        // SETN 8; LDV pxl=1 then INCRI with valid held: no bubble
        send("SETN 8", 4'h2, 28'd8);     tick();
        send("LDV", 4'h6, {1'b1, 27'd0}); tick();
        send("INCRI", 4'h0, 28'd0);
        beat_check("ldv.b0", 8'b1011_0000, 4'b1111, 4'd0, 1'b1, 1'b0); tick();
        beat_check("ldv.b1", 8'b1011_0000, 4'b1111, 4'd1, 1'b0, 1'b1); tick();
        beat_check("incri",  8'b1010_0010, 4'b0000, 4'd0, 1'b0, 1'b1);
        instr_valid = 1'b0;              tick();
        check("incri.clear", 32'(strb), 32'h0000_00A0);

        // SETN 16; SUMFV 4 beats, reset during beat 1
        send("SETN 16", 4'h2, 28'd16);   tick();
        send("SUMFV", 4'h3, 28'd0);      tick();
        instr_valid = 1'b0;
        beat_check("sumr.b0", 8'b0010_0100, 4'b1111, 4'd0, 1'b1, 1'b0); tick();
        beat_check("sumr.b1", 8'b0010_0100, 4'b1111, 4'd1, 1'b1, 1'b0);
        rst = 1'b1;                      tick();
        beat_check("midrst", 8'h00, 4'h0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0; #1;
        check("midrst.ready", 32'(instr_ready), 32'd1);
        // vlen back to 4: SUMFV is a single full beat
        send("SUMFV", 4'h3, 28'd0);      tick();
        instr_valid = 1'b0;
        beat_check("sumv4.b0", 8'b0000_0100, 4'b1111, 4'd0, 1'b0, 1'b1); tick();
        beat_check("sumv4.idle", 8'b0000_0000, 4'b0000, 4'd0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
